// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//
// Purpose:
//   Load-use hazard detection and operand forwarding for a classic five-stage
//   pipeline. The unit keeps its own shadow copy of the EX and MEM stage
//   instructions (valid, writes-register, destination, is-load). From these it
//   decides:
//     - whether the instruction currently in ID must stall one cycle because
//       it reads the result of a load that is still in EX, and
//     - where each ID-stage source operand should come from (register file,
//       EX ALU result, MEM ALU result or MEM load data).
//   A saturating counter records the number of stall cycles.
//
// Ports:
//   clock                     in   single clock, rising-edge active
//   reset                     in   asynchronous, active-high; clears all state
//   idValid                   in   ID-stage instruction is real (0 = bubble)
//   idRs, idRt                in   ID-stage source register numbers [4:0]
//   idUsesRs, idUsesRt        in   ID-stage instruction reads that source
//   idWriteRegister           in   ID-stage instruction writes a register
//   idDestination             in   ID-stage destination register [4:0]
//   idIsLoad                  in   ID-stage instruction is a load
//   shouldStall               out  hold PC and IF/ID, inject bubble into EX
//   registerRsForwardControl  out  rs operand select [1:0]
//   registerRtForwardControl  out  rt operand select [1:0]
//   stallCount                out  saturating count of stall cycles [15:0]
//
// Forward select encoding:
//   00 register file, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data

module hazard_forward_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        idValid,
  input  logic [4:0]  idRs,
  input  logic [4:0]  idRt,
  input  logic        idUsesRs,
  input  logic        idUsesRt,
  input  logic        idWriteRegister,
  input  logic [4:0]  idDestination,
  input  logic        idIsLoad,
  output logic        shouldStall,
  output logic [1:0]  registerRsForwardControl,
  output logic [1:0]  registerRtForwardControl,
  output logic [15:0] stallCount
);

  localparam logic [1:0] SelRegFile = 2'b00;
  localparam logic [1:0] SelExAlu   = 2'b01;
  localparam logic [1:0] SelMemAlu  = 2'b10;
  localparam logic [1:0] SelMemLoad = 2'b11;

  // EX shadow slot
  logic       exValid_q, exValid_d;
  logic       exWrite_q, exWrite_d;
  logic [4:0] exDest_q, exDest_d;
  logic       exIsLoad_q, exIsLoad_d;

  // MEM shadow slot
  logic       memValid_q;
  logic       memWrite_q;
  logic [4:0] memDest_q;
  logic       memIsLoad_q;

  logic [15:0] stallCount_q, stallCount_d;

  // A slot only produces a forwardable value when it holds a real instruction
  // that writes a non-zero register; r0 is hardwired to zero so it never
  // forwards or stalls.
  function automatic logic slotMatches(input logic valid, input logic write,
                                       input logic [4:0] dest,
                                       input logic [4:0] r);
    return valid && write && (dest == r) && (r != 5'd0);
  endfunction

  // EX is checked before MEM so that the youngest producer wins. A load in EX
  // selects the register file here because the stall holds the consumer until
  // the load data is available from MEM. WB is never forwarded: the register
  // file writes in the first half-cycle and reads in the second.
  function automatic logic [1:0] selectSource(input logic [4:0] r,
      input logic exV, input logic exW, input logic [4:0] exD, input logic exL,
      input logic memV, input logic memW, input logic [4:0] memD, input logic memL);
    logic [1:0] sel;
    sel = SelRegFile;
    if (slotMatches(exV, exW, exD, r)) begin
      sel = exL ? SelRegFile : SelExAlu;
    end else if (slotMatches(memV, memW, memD, r)) begin
      sel = memL ? SelMemLoad : SelMemAlu;
    end
    return sel;
  endfunction

  // Load-use detection. Everything is gated by idValid first so that
  // undefined source fields of a bubble never reach the output.
  always_comb begin
    shouldStall = 1'b0;
    if (idValid && exIsLoad_q) begin
      if (idUsesRs && slotMatches(exValid_q, exWrite_q, exDest_q, idRs)) begin
        shouldStall = 1'b1;
      end
      if (idUsesRt && slotMatches(exValid_q, exWrite_q, exDest_q, idRt)) begin
        shouldStall = 1'b1;
      end
    end
  end

  // Forward selects; an unused source or a bubble always reads the register file.
  always_comb begin
    registerRsForwardControl = SelRegFile;
    registerRtForwardControl = SelRegFile;
    if (idValid) begin
      if (idUsesRs) begin
        registerRsForwardControl = selectSource(idRs,
          exValid_q, exWrite_q, exDest_q, exIsLoad_q,
          memValid_q, memWrite_q, memDest_q, memIsLoad_q);
      end
      if (idUsesRt) begin
        registerRtForwardControl = selectSource(idRt,
          exValid_q, exWrite_q, exDest_q, exIsLoad_q,
          memValid_q, memWrite_q, memDest_q, memIsLoad_q);
      end
    end
  end

  // Next EX contents. A stall or an invalid ID instruction both insert a clean
  // bubble, so undefined id* fields of a bubble never enter the slot state.
  always_comb begin
    exValid_d  = 1'b0;
    exWrite_d  = 1'b0;
    exDest_d   = 5'd0;
    exIsLoad_d = 1'b0;
    if (idValid && !shouldStall) begin
      exValid_d  = 1'b1;
      exWrite_d  = idWriteRegister;
      exDest_d   = idDestination;
      exIsLoad_d = idIsLoad;
    end
  end

  // Stall counter saturates at all-ones instead of wrapping.
  always_comb begin
    stallCount_d = stallCount_q;
    if (shouldStall && (stallCount_q != 16'hFFFF)) begin
      stallCount_d = stallCount_q + 16'd1;
    end
  end

  // Shadow pipeline and counter registers; MEM always takes the old EX.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exValid_q    <= 1'b0;
      exWrite_q    <= 1'b0;
      exDest_q     <= 5'd0;
      exIsLoad_q   <= 1'b0;
      memValid_q   <= 1'b0;
      memWrite_q   <= 1'b0;
      memDest_q    <= 5'd0;
      memIsLoad_q  <= 1'b0;
      stallCount_q <= 16'd0;
    end else begin
      memValid_q   <= exValid_q;
      memWrite_q   <= exWrite_q;
      memDest_q    <= exDest_q;
      memIsLoad_q  <= exIsLoad_q;
      exValid_q    <= exValid_d;
      exWrite_q    <= exWrite_d;
      exDest_q     <= exDest_d;
      exIsLoad_q   <= exIsLoad_d;
      stallCount_q <= stallCount_d;
    end
  end

  assign stallCount = stallCount_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit
//
// Purpose:
//   Self-checking bench for hazard_forward_unit. A behavioural model keeps the
//   last two issued instructions as records and derives the expected stall,
//   forward selects and stall count from the hazard rules. Directed steps
//   cover forwarding, load-use, register zero, priority, saturation and
//   asynchronous reset; a randomized section follows.

module tb_hazard_forward_unit;

  typedef struct packed {
    logic       valid;
    logic       write;
    logic [4:0] dest;
    logic       isLoad;
  } instr_t;

  logic        clock;
  logic        reset;
  logic        idValid;
  logic [4:0]  idRs;
  logic [4:0]  idRt;
  logic        idUsesRs;
  logic        idUsesRt;
  logic        idWriteRegister;
  logic [4:0]  idDestination;
  logic        idIsLoad;
  logic        shouldStall;
  logic [1:0]  registerRsForwardControl;
  logic [1:0]  registerRtForwardControl;
  logic [15:0] stallCount;

  int compareCount = 0;
  int failCount    = 0;

  // Model state: the instruction one stage ahead (EX) and two ahead (MEM).
  instr_t modelEx;
  instr_t modelMem;
  int     modelCount;
  logic   modelStall;

  hazard_forward_unit dut (
    .clock                    (clock),
    .reset                    (reset),
    .idValid                  (idValid),
    .idRs                     (idRs),
    .idRt                     (idRt),
    .idUsesRs                 (idUsesRs),
    .idUsesRt                 (idUsesRt),
    .idWriteRegister          (idWriteRegister),
    .idDestination            (idDestination),
    .idIsLoad                 (idIsLoad),
    .shouldStall              (shouldStall),
    .registerRsForwardControl (registerRsForwardControl),
    .registerRtForwardControl (registerRtForwardControl),
    .stallCount               (stallCount)
  );

  // 10 time-unit clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // An older instruction supplies register r if it is real, writes, and r is not r0.
  function automatic logic produces(input instr_t older, input logic [4:0] r);
    return older.valid && older.write && older.dest == r && r != 0;
  endfunction

  // Expected operand source: youngest producer first; load in EX waits via stall.
  function automatic logic [1:0] expectedSelect(input logic used, input logic [4:0] r);
    if (!idValid || !used) return 2'd0;
    if (produces(modelEx, r))  return modelEx.isLoad ? 2'd0 : 2'd1;
    if (produces(modelMem, r)) return modelMem.isLoad ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  function automatic logic expectedStall();
    if (!idValid || !modelEx.isLoad) return 1'b0;
    return (idUsesRs && produces(modelEx, idRs)) || (idUsesRt && produces(modelEx, idRt));
  endfunction

  // One comparison: count it, and on disagreement count and report the failure.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one ID-stage instruction.
  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic ur, input logic ut, input logic w,
                               input logic [4:0] d, input logic ld);
    idValid         = v;
    idRs            = rs;
    idRt            = rt;
    idUsesRs        = ur;
    idUsesRt        = ut;
    idWriteRegister = w;
    idDestination   = d;
    idIsLoad        = ld;
  endtask

  // Present an instruction at the falling edge and check outputs against the model.
  task automatic presentInstr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic ur, input logic ut, input logic w,
                              input logic [4:0] d, input logic ld);
    @(negedge clock);
    applyStimulus(v, rs, rt, ur, ut, w, d, ld);
    #1;
    modelStall = expectedStall();
    checkOutput("stall", {15'd0, shouldStall}, {15'd0, modelStall});
    checkOutput("fwdRs", {14'd0, registerRsForwardControl}, {14'd0, expectedSelect(idUsesRs, idRs)});
    checkOutput("fwdRt", {14'd0, registerRtForwardControl}, {14'd0, expectedSelect(idUsesRt, idRt)});
    checkOutput("count", stallCount, modelCount[15:0]);
  endtask

  // Rising edge: the issued instruction (or a bubble on stall) moves into EX.
  task automatic advance();
    instr_t issued;
    @(posedge clock);
    issued = '0;
    if (idValid && !modelStall) issued = '{1'b1, idWriteRegister, idDestination, idIsLoad};
    modelMem = modelEx;
    modelEx  = issued;
    if (modelStall && modelCount < 65535) modelCount++;
  endtask

  task automatic resetModel();
    modelEx    = '0;
    modelMem   = '0;
    modelCount = 0;
    modelStall = 1'b0;
  endtask

  initial begin
    resetModel();
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

    // Reset state, even with a would-be hazardous reader presented.
    @(negedge clock);
    applyStimulus(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    checkOutput("rst_stall", {15'd0, shouldStall}, 16'd0);
    checkOutput("rst_fwdRs", {14'd0, registerRsForwardControl}, 16'd0);
    checkOutput("rst_fwdRt", {14'd0, registerRtForwardControl}, 16'd0);
    checkOutput("rst_count", stallCount, 16'd0);
    @(negedge clock);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    reset = 1'b0;

    // ALU-to-ALU forwarding from EX, then from MEM.
    presentInstr(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);   advance();
    presentInstr(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("exFwd_rs", {14'd0, registerRsForwardControl}, 16'd1);
    checkOutput("exFwd_stall", {15'd0, shouldStall}, 16'd0);
    advance();
    presentInstr(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("memFwd_rs", {14'd0, registerRsForwardControl}, 16'd2);
    advance();

    // Load-use: one stall cycle, then load data from MEM.
    presentInstr(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);   advance();
    presentInstr(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("loadUse_stall", {15'd0, shouldStall}, 16'd1);
    advance();
    presentInstr(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("loadUse_after", {15'd0, shouldStall}, 16'd0);
    checkOutput("loadUse_rt", {14'd0, registerRtForwardControl}, 16'd3);
    checkOutput("loadUse_count", stallCount, 16'd1);
    advance();

    // Register zero never forwards nor stalls.
    presentInstr(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);   advance();
    presentInstr(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("r0_rs", {14'd0, registerRsForwardControl}, 16'd0);
    checkOutput("r0_stall", {15'd0, shouldStall}, 16'd0);
    advance();
    presentInstr(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1);   advance();
    presentInstr(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("r0load_stall", {15'd0, shouldStall}, 16'd0);
    advance();

    // Youngest producer wins; JAL writes r31.
    presentInstr(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);   advance();
    presentInstr(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);   advance();
    presentInstr(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("prio_rs", {14'd0, registerRsForwardControl}, 16'd1);
    checkOutput("prio_rt", {14'd0, registerRtForwardControl}, 16'd1);
    advance();
    presentInstr(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0);  advance();
    presentInstr(1'b1, 5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("jal_rs", {14'd0, registerRsForwardControl}, 16'd1);
    advance();

    // Saturation: preload the counter close to the top, then keep stalling.
    #2;
    dut.stallCount_q = 16'hFFF0;
    modelCount = 16'hFFF0;
    for (int i = 0; i < 44; i++) begin
      presentInstr(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
      advance();
    end
    presentInstr(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
    checkOutput("sat_count", stallCount, 16'hFFFF);
    advance();
    presentInstr(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("sat_hold", stallCount, 16'hFFFF);
    advance();

    // Randomized traffic over a small register range so hazards are frequent;
    // bubbles carry undefined fields.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        presentInstr(1'b0, 'x, 'x, 'x, 'x, 'x, 'x, 'x);
      end else begin
        presentInstr(1'b1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     1'($urandom), 1'($urandom), 1'($urandom),
                     5'($urandom_range(0, 7)), 1'($urandom));
      end
      advance();
    end

    // Asynchronous reset in the middle of a stall.
    presentInstr(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1);   advance();
    presentInstr(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("midStall_pre", {15'd0, shouldStall}, 16'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midStall_stall", {15'd0, shouldStall}, 16'd0);
    checkOutput("midStall_count", stallCount, 16'd0);
    checkOutput("midStall_rs", {14'd0, registerRsForwardControl}, 16'd0);
    resetModel();
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    presentInstr(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("postRst_stall", {15'd0, shouldStall}, 16'd0);
    checkOutput("postRst_rs", {14'd0, registerRsForwardControl}, 16'd0);
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
